// File: rtl/project_switch_sequencer.sv
// Sequenced project switchover for the multi-project harness: isolate pads, change select, hold reset.
// Optional auto-rotation dwell timer is built when PSEQ_AUTOROTATE_EN is defined.
module project_switch_sequencer #(
  parameter int          NUM_PROJECTS   = 6,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0800,
  parameter int          ISOLATE_CYCLES = 4,
  parameter int          RESET_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  active_project,
  output logic        io_isolate,
  output logic        proj_reset,
  output logic        switch_done
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_ISOLATE = 2'd1;
  localparam logic [1:0] ST_RESET   = 2'd2;

  localparam int CNT_MAX = (ISOLATE_CYCLES > RESET_CYCLES) ? ISOLATE_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISOLATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [7:0] NUM_P8  = 8'(NUM_PROJECTS);
  localparam logic [7:0] LAST_ID = 8'(NUM_PROJECTS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] phase_cnt;
  logic [7:0]       pending_target;
  logic [7:0]       ctrl_target;
  logic             err;

  // Wishbone classic handshake: a request is taken on the edge where stb&cyc is
  // high and ack is low; ack is high for exactly the following cycle, so a master
  // holding stb until ack sees each request acted on once.
  logic       in_window;
  logic [1:0] offset;
  logic       wb_take;
  logic       wr_full;
  logic       ctrl_wr;
  logic       dwell_wr;
  logic       errclr_wr;
  logic [7:0] wr_target;
  logic       in_run;
  logic       ctrl_go;
  logic [7:0] next_rot;
  logic       start_req;
  logic [7:0] start_target;
  logic [31:0] rd_data;
  logic       unused_bits;

  assign in_window = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign offset    = wbs_adr_i[3:2];
  assign wb_take   = wbs_stb_i & wbs_cyc_i & in_window & ~wbs_ack_o;
  assign wr_full   = wb_take & wbs_we_i & (wbs_sel_i == 4'hF);
  assign ctrl_wr   = wr_full & (offset == 2'd0);
  assign dwell_wr  = wr_full & (offset == 2'd1);
  assign errclr_wr = wr_full & (offset == 2'd3);
  assign wr_target = wbs_dat_i[7:0];
  assign in_run    = (state == ST_RUN);
  assign ctrl_go   = ctrl_wr & (wr_target < NUM_P8) & in_run;
  assign next_rot  = (active_project == LAST_ID) ? 8'd0 : active_project + 8'd1;

  logic        auto_en;
  logic [31:0] dwell;
  logic        dwell_expiry;

`ifdef PSEQ_AUTOROTATE_EN
  logic [31:0] dwell_cnt;

  // Register writes restart the dwell period and take priority over an expiry.
  assign dwell_expiry = in_run & auto_en & (dwell != 32'd0) &
                        (dwell_cnt == dwell - 32'd1) & ~ctrl_wr & ~dwell_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_en   <= 1'b0;
      dwell     <= 32'd0;
      dwell_cnt <= 32'd0;
    end else begin
      if (ctrl_wr) auto_en <= wbs_dat_i[8];
      if (dwell_wr) dwell <= wbs_dat_i;
      if (!in_run || ctrl_wr || dwell_wr || dwell_expiry)
        dwell_cnt <= 32'd0;
      else if (auto_en && (dwell != 32'd0))
        dwell_cnt <= dwell_cnt + 32'd1;
    end
  end

  assign unused_bits = ^wbs_adr_i[1:0];
`else
  assign auto_en      = 1'b0;
  assign dwell        = 32'd0;
  assign dwell_expiry = 1'b0;
  assign unused_bits  = ^{wbs_adr_i[1:0], wbs_dat_i[31:8]};
`endif

  assign start_req    = ctrl_go | dwell_expiry;
  assign start_target = ctrl_go ? wr_target : next_rot;

  always_comb begin
    rd_data = 32'd0;
    case (offset)
      2'd0:    rd_data = {23'd0, auto_en, ctrl_target};
      2'd1:    rd_data = dwell;
      2'd2:    rd_data = {15'd0, err, 6'd0, state, active_project};
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= wbs_stb_i & wbs_cyc_i & in_window & ~wbs_ack_o;
      wbs_dat_o <= (wb_take & ~wbs_we_i) ? rd_data : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_target <= 8'd0;
      err         <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_target <= wr_target;
      if (errclr_wr)
        err <= 1'b0;
      else if (ctrl_wr && !ctrl_go)
        err <= 1'b1;
    end
  end

  // Reset lands in RESET so the first RESET_CYCLES cycles keep projects held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RESET;
      phase_cnt      <= '0;
      pending_target <= 8'd0;
      active_project <= 8'd0;
      switch_done    <= 1'b0;
    end else begin
      switch_done <= (state == ST_RESET) && (phase_cnt == RST_LAST);
      case (state)
        ST_RUN: begin
          if (start_req) begin
            state          <= ST_ISOLATE;
            phase_cnt      <= '0;
            pending_target <= start_target;
          end
        end
        ST_ISOLATE: begin
          if (phase_cnt == ISO_LAST) begin
            state          <= ST_RESET;
            phase_cnt      <= '0;
            active_project <= pending_target;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_RESET: begin
          if (phase_cnt == RST_LAST) begin
            state     <= ST_RUN;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_RESET;
          phase_cnt <= '0;
        end
      endcase
    end
  end

  assign io_isolate = (state != ST_RUN);
  assign proj_reset = (state == ST_RESET);

endmodule

// File: tb/tb_project_switch_sequencer.sv
// Bench for project_switch_sequencer: every cycle compares outputs against a time-window model.
// Auto-rotation steps run only when PSEQ_AUTOROTATE_EN is defined.
module tb_project_switch_sequencer;
  localparam int N   = 6;
  localparam int ISO = 4;
  localparam int RST = 16;
  localparam logic [31:0] BASE = 32'h3000_0800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [7:0]  active_project;
  logic        io_isolate;
  logic        proj_reset;
  logic        switch_done;

  project_switch_sequencer #(
    .NUM_PROJECTS(N), .BASE_ADDR(BASE), .ISOLATE_CYCLES(ISO), .RESET_CYCLES(RST)
  ) dut (
    .clk(clk), .reset(reset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .active_project(active_project), .io_isolate(io_isolate),
    .proj_reset(proj_reset), .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  // Model: the most recent switch started at edge m_t0; pads isolated for
  // edges [t0, t0+ISO+RST), project reset for [t0+ISO, t0+ISO+RST).
  int          m_t0;
  logic [7:0]  m_old;
  logic [7:0]  m_new;
  logic [7:0]  m_ctrl_tgt;
  bit          m_in_reset;
  bit          m_err;
  bit          m_auto;
  logic [31:0] m_dwell;
  int          m_last_wr;

  function automatic bit m_busy(input int c);
    return (c >= m_t0) && (c < m_t0 + ISO + RST);
  endfunction

  function automatic logic [7:0] m_active(input int c);
    return (c >= m_t0 + ISO) ? m_new : m_old;
  endfunction

  function automatic logic [1:0] m_state(input int c);
    if (!m_busy(c)) return 2'd0;
    return (c < m_t0 + ISO) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] off, input int c);
    case (off)
`ifdef PSEQ_AUTOROTATE_EN
      2'd0: return {23'd0, m_auto, m_ctrl_tgt};
      2'd1: return m_dwell;
`else
      2'd0: return {24'd0, m_ctrl_tgt};
      2'd1: return 32'd0;
`endif
      2'd2: return {15'd0, m_err, 6'd0, m_state(c), m_active(c)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic start_switch(input int t, input logic [7:0] tgt);
    m_old = m_new;
    m_new = tgt;
    m_t0  = t;
  endtask

  task automatic predict_write(input int t, input logic [1:0] off,
                               input logic [31:0] dat, input logic [3:0] sel);
    if (sel != 4'hF) return;
    case (off)
      2'd0: begin
        m_ctrl_tgt = dat[7:0];
`ifdef PSEQ_AUTOROTATE_EN
        m_auto = dat[8];
`endif
        m_last_wr = t;
        if (dat[7:0] >= 8'(N) || m_busy(t - 1)) m_err = 1'b1;
        else start_switch(t, dat[7:0]);
      end
      2'd1: begin
`ifdef PSEQ_AUTOROTATE_EN
        m_dwell = dat;
`endif
        m_last_wr = t;
      end
      2'd3: m_err = 1'b0;
      default: ;
    endcase
  endtask

  // Rotation fires DWELL edges after the later of RUN entry and the last register write.
  task automatic model_auto(input int c);
    int r;
    int anchor;
    if (m_in_reset || !m_auto || m_dwell == 32'd0) return;
    r = m_t0 + ISO + RST;
    anchor = (m_last_wr > r) ? m_last_wr : r;
    if (c == anchor + int'(m_dwell))
      start_switch(c, (m_new == 8'(N - 1)) ? 8'd0 : 8'(m_new + 8'd1));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_auto(cyc);
    if (m_in_reset) begin
      check("rst_active", 32'(active_project), 32'd0);
      check("rst_isolate", 32'(io_isolate), 32'd1);
      check("rst_proj_reset", 32'(proj_reset), 32'd1);
      check("rst_done", 32'(switch_done), 32'd0);
    end else begin
      check("active", 32'(active_project), 32'(m_active(cyc)));
      check("isolate", 32'(io_isolate), 32'(m_busy(cyc)));
      check("proj_reset", 32'(proj_reset), 32'(m_state(cyc) == 2'd2));
      check("switch_done", 32'(switch_done), 32'(cyc == m_t0 + ISO + RST));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_run(input int max_cycles);
    for (int i = 0; i < max_cycles && m_busy(cyc); i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    m_in_reset = 1'b1;
    idle(n);
    reset = 1'b0;
    m_in_reset = 1'b0;
    m_t0 = cyc - ISO;
    m_old = 8'd0;
    m_new = 8'd0;
    m_ctrl_tgt = 8'd0;
    m_err = 1'b0;
    m_auto = 1'b0;
    m_dwell = 32'd0;
    m_last_wr = -1000;
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    bit in_win;
    logic [31:0] exp_rd;
    in_win = (adr[31:4] == BASE[31:4]);
    exp_rd = 32'd0;
    if (in_win && !we) exp_rd = model_read(adr[3:2], cyc);
    if (in_win && we) predict_write(cyc + 1, adr[3:2], dat, sel);
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    step();
    rd = wbs_dat_o;
    if (in_win) begin
      check("ack", 32'(wbs_ack_o), 32'd1);
      check("rdata", wbs_dat_o, exp_rd);
    end else begin
      check("oow_ack", 32'(wbs_ack_o), 32'd0);
      idle(2);
      check("oow_ack_late", 32'(wbs_ack_o), 32'd0);
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    step();
    check("ack_single", 32'(wbs_ack_o), 32'd0);
    check("rdata_idle", wbs_dat_o, 32'd0);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] dat);
    logic [31:0] rd;
    wb_xfer(BASE + {28'd0, off, 2'b00}, 1'b1, dat, 4'hF, rd);
  endtask

  task automatic rd_chk(input logic [1:0] off);
    logic [31:0] rd;
    wb_xfer(BASE + {28'd0, off, 2'b00}, 1'b0, 32'd0, 4'hF, rd);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int r;
    do_reset(3);
    idle(RST + 4);
    check("boot_active", 32'(active_project), 32'd0);
    rd_chk(2'd2);

    // Plain switch to 3, then readback of CTRL and STATUS.
    wr(2'd0, 32'h3);
    wait_run(40);
    idle(2);
    rd_chk(2'd0);
    rd_chk(2'd2);

    // Out-of-range target raises err; ERRCLR drops it.
    wr(2'd0, 32'h7);
    idle(3);
    rd_chk(2'd2);
    wr(2'd3, 32'h0);
    rd_chk(2'd2);

    // Write during ISOLATE is dropped, sequence completes to the first target.
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h2);
    wait_run(40);
    idle(2);
    check("iso_write_target", 32'(active_project), 32'd1);
    rd_chk(2'd2);
    wr(2'd3, 32'h0);

    // Partial byte select is acked and ignored; out-of-window never acked.
    wb_xfer(BASE, 1'b1, 32'h4, 4'h3, rd);
    idle(3);
    rd_chk(2'd0);
    wb_xfer(BASE + 32'h10, 1'b1, 32'h4, 4'hF, rd);
    wb_xfer(32'h3000_0000, 1'b0, 32'h0, 4'hF, rd);
    rd_chk(2'd1);

    // Same-ID write performs a full re-sequence.
    wr(2'd0, 32'h1);
    wait_run(40);
    idle(2);

`ifdef PSEQ_AUTOROTATE_EN
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h105);
    wait_run(40);
    for (int i = 0; i < 150 && !m_busy(cyc); i++) step();
    wait_run(40);
    check("rot_target", 32'(active_project), 32'd0);
    r = m_t0 + ISO + RST;
    while (cyc < r + 99) step();
    wr(2'd0, 32'h103);
    wait_run(40);
    idle(2);
    check("override_target", 32'(active_project), 32'd3);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h004);
    wait_run(40);
    rd_chk(2'd1);
`endif

    // Reset during the RESET phase aborts back to project 0.
    wr(2'd0, 32'h5);
    idle(ISO + 3);
    do_reset(2);
    idle(RST + 4);
    rd_chk(2'd2);

    for (int it = 0; it < 40; it++) begin
      int op;
      logic [31:0] d;
      idle($urandom_range(0, 25));
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          d = {23'd0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7))};
          wb_xfer(BASE, 1'b1, d, ($urandom_range(0, 7) == 0) ? 4'h3 : 4'hF, rd);
        end
        2: rd_chk(2'd2);
        3: wr(2'd3, 32'h0);
        4: wr(2'd1, 32'($urandom_range(0, 30)));
        default: rd_chk(2'($urandom_range(0, 1)));
      endcase
    end
    wr(2'd0, 32'h0);
    wait_run(200);
    idle(5);
    rd_chk(2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/project_switch_sequencer.md
# project_switch_sequencer

Wishbone-configured controller that owns project selection for the multi-project harness. It replaces the direct write-to-select register with a sequenced switchover: isolate the pads, change the selected project, then hold the incoming project in reset before releasing it. An optional dwell timer rotates through projects automatically. Its outputs drive the harness I/O mux select, a pad-isolation override on `io_oeb`, and the shared project reset.

## Interface
- `NUM_PROJECTS`, 6: number of selectable projects; valid IDs are 0..NUM_PROJECTS-1.
- `BASE_ADDR`, 32'h30000800: base of the 16-byte register window.
- `ISOLATE_CYCLES`, 4: cycles pads stay isolated before the select changes; must be ≥1.
- `RESET_CYCLES`, 16: cycles `proj_reset` is held after the select changes; must be ≥1.

Ports (clock and reset: `reset`, synchronous, active-high; clock `clk`):
- `clk`  in  1  system clock (wb_clk_i)
- `reset`  in  1  synchronous active-high reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle, write enable
- `wbs_sel_i`  in  4  byte selects
- `wbs_adr_i`  in  32  address
- `wbs_dat_i`  in  32  write data
- `wbs_ack_o`  out  1  registered ack
- `wbs_dat_o`  out  32  read data, valid with ack, 0 otherwise
- `active_project`  out  8  harness mux select
- `io_isolate`  out  1  when high the harness forces `io_oeb` to all-ones
- `proj_reset`  out  1  ORed into every project's reset
- `switch_done`  out  1  one-cycle pulse on return to RUN

## Operation
- Registers (offset from BASE_ADDR; all writes require `wbs_sel_i`=4'hF, other writes are acked and ignored):
  - 0x0 CTRL (R/W): [7:0] target ID; [8] auto_en. A write requests a switch to [7:0].
  - 0x4 DWELL (R/W): 32-bit auto-rotate period in cycles; 0 disables rotation. Reset value 0.
  - 0x8 STATUS (RO): [7:0] active_project; [9:8] state (0 RUN, 1 ISOLATE, 2 RESET); [16] err (sticky).
  - 0xC ERRCLR (WO): any write clears err.
- Any access inside the window is acked. Accesses outside the window are never acked.
- Ack rule: `wbs_ack_o` is set the cycle after `stb&cyc` is sampled and is cleared the cycle after. It is never high two consecutive cycles, so no request is double-counted.
- FSM:
  - RUN → ISOLATE on a valid switch request; the phase counter loads 0.
  - ISOLATE: `io_isolate`=1. After ISOLATE_CYCLES cycles → RESET, and `active_project` takes the pending target on that same edge.
  - RESET: `io_isolate`=1, `proj_reset`=1. After RESET_CYCLES cycles → RUN.
  - RUN entry: `switch_done`=1 for one cycle; `io_isolate`=0, `proj_reset`=0.
- Switch request rules:
  - A target ≥ NUM_PROJECTS sets err; the request is dropped and auto_en is still updated.
  - A target equal to the current ID is valid and performs a full re-sequence (soft reset of that project).
  - A CTRL write while not in RUN is acked but dropped, and sets err; auto_en is still updated.
- Auto rotation (macro-gated): in RUN with auto_en=1 and DWELL≠0, a dwell counter increments each cycle. When it reaches DWELL-1, a request is made for (active_project+1) mod NUM_PROJECTS and the counter clears. The counter clears on leaving RUN and on any DWELL or CTRL write.
- A CTRL write and a dwell expiry in the same cycle: the CTRL write wins and the expiry is discarded.

## Timing
- Reset values:
  - `active_project`=0, `io_isolate`=1, `proj_reset`=1, `wbs_ack_o`=0, `wbs_dat_o`=0, `switch_done`=0, err=0, auto_en=0, DWELL=0.
  - The state after reset is RESET with the counter at 0, so the first RESET_CYCLES cycles after reset deassertion keep the projects in reset; then the block enters RUN and pulses `switch_done`.
- Reset asserted mid-sequence aborts to the reset state above, and `active_project` returns to 0.
- Switch timing, with the CTRL write sampled at edge T:
  - ack and `io_isolate` rise at T+1.
  - `active_project` changes and `proj_reset` rises at T+1+ISOLATE_CYCLES.
  - RUN is entered and `switch_done` pulses at T+1+ISOLATE_CYCLES+RESET_CYCLES.
- STATUS reads reflect register values at the sampling edge.

## Configuration
- `PSEQ_AUTOROTATE_EN` defined: dwell counter, DWELL register and auto_en behave as above.
- Not defined:
  - No dwell counter is built.
  - DWELL reads 0 and writes to it are acked and ignored.
  - CTRL[8] reads 0.
  - Switches occur only on CTRL writes.

## Test plan
- Reset release: hold reset 3 cycles, then release → `proj_reset`=1 for 16 cycles, `switch_done` pulse, then `io_isolate`=0 and `active_project`=0.
- Write CTRL=0x3 at edge T → ack at T+1; `io_isolate` high T+1..T+20; `active_project`=3 from T+5; `proj_reset` high T+5..T+20; `switch_done` at T+21.
- Write CTRL=0x7 (NUM_PROJECTS=6) → acked, `active_project` unchanged, STATUS[16]=1; a write to ERRCLR clears it.
- Write CTRL=0x2 during ISOLATE → acked, err=1, the sequence completes to the original target.
- With the macro defined: DWELL=100, CTRL=0x105 → after settling on 5, the next switch targets 0 and begins 100 cycles after RUN entry; a CTRL write on the expiry cycle overrides the rotation.
- Reset asserted during RESET state → next cycle `active_project`=0 and `proj_reset`=1, and the post-reset sequence repeats.
